wb_b3_burst_master: RTL and testbench
=====================================

Name: wb_b3_burst_master

Overview:
- Wishbone B3 initiator that turns a simple command plus data-stream interface into classic single or registered-feedback burst cycles. Bursts are incrementing (linear, or 4/8/16-beat wrap).
- It is the bus-side counterpart of the team's B3 memory slaves. Test benches, loaders and small DMA engines use it to read and write memory without hand-driving cti/bte.
- Data width is 32 bits, with 4-byte words and full byte select on every beat.

Parameters:
- dw, 32, data width. Only 32 is supported.
- aw, 32, Wishbone address width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  aw  byte start address. Bits [1:0] are ignored.
- cmd_len  in  4  linear-burst beats minus 1 (0 = single beat). Used only when cmd_bte = 00.
- cmd_bte  in  2  00 = linear, 01 = wrap4, 10 = wrap8, 11 = wrap16.
- wr_data  in  dw  write data stream.
- wr_valid  in  1  write word available.
- wr_ready  out  1  write word consumed this cycle.
- rd_data  out  dw  read data, registered.
- rd_valid  out  1  rd_data valid, one pulse per beat. There is no backpressure.
- done  out  1  one-cycle pulse at the end of the command.
- done_err  out  1  qualifies done: 1 = terminated by err or rty.
- done_beats  out  5  beats acked for the last command. Held until the next accept.
- wb_adr_o  out  aw  bus address.
- wb_dat_o  out  dw  bus write data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  write enable.
- wb_cti_o  out  3  cycle type.
- wb_bte_o  out  2  burst type.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_dat_i  in  dw  bus read data.
- wb_ack_i  in  1  ack.
- wb_err_i  in  1  error.
- wb_rty_i  in  1  retry.

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready = 1.
  - State IDLE, beat counter 0, done_beats 0.
- Reset is asynchronous: cyc and stb drop immediately, even mid-burst. No done pulse is generated for the aborted command.
- FSM states are IDLE, BUS and DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch we, adr (with [1:0] = 0), beat total and bte, then go to BUS.
  - Beat total is cmd_len+1 for linear, otherwise 4, 8 or 16 (cmd_len is ignored for wrap bursts).
- BUS, bus signals:
  - wb_cyc_o = 1 throughout BUS.
  - wb_sel_o = 4'hf.
  - wb_we_o = latched we.
  - wb_adr_o = current beat address.
- BUS, strobe and write data:
  - Reads: wb_stb_o = 1.
  - Writes: wb_stb_o = wr_valid, so a missing write word inserts a wait state with cyc held high.
  - wb_dat_o = wr_data, combinationally.
  - wr_ready = wb_stb_o & wb_we_o & wb_ack_i.
- BUS, cycle type:
  - Total of 1 beat: cti = 000 and bte = 00.
  - Otherwise cti = 010 on every beat except the last, and cti = 111 on the last. bte = latched bte.
- On an ack beat:
  - Increment the beat counter.
  - Advance the address by 4 bytes. Linear carries through the full address. wrap4, wrap8 and wrap16 increment only word-address bits [1:0], [2:0] and [3:0] respectively, and upper bits hold.
  - For reads, rd_data <= wb_dat_i and rd_valid = 1 on the next cycle.
- Ack on the last beat: the next cycle has cyc = stb = 0, the state is DONE, done = 1 and done_err = 0.
- Error or retry:
  - wb_err_i or wb_rty_i with stb high terminates immediately.
  - The next cycle has cyc = stb = 0, the state is DONE, done = 1 and done_err = 1.
  - The failing beat is not counted, and no rd_valid or wr_ready is produced for it.
  - rty is treated as an abort; the block never re-issues.
- Simultaneous ack with err: err wins.
- An ack arriving while stb is low is ignored.
- DONE:
  - Lasts exactly one cycle, with cmd_ready = 0, then returns to IDLE.
  - Minimum gap between commands is therefore 2 idle bus cycles.
- done_beats is updated in DONE and reads 0..16.
- No timeout: a slave that never responds hangs the block until reset.

Test Plan:
- Single read at 0x0000_0040, slave acks:
  - Bus shows cti = 000 and adr 0x40 for one beat.
  - rd_valid pulses once, on the cycle after the ack.
  - done = 1, done_err = 0, done_beats = 1.
- Linear write, cmd_len = 3, at 0x100:
  - wr_valid is low for 2 cycles before beat 3.
  - Addresses are 0x100, 0x104, 0x108, 0x10C, with cti 010, 010, 010, 111.
  - stb is low during the gap while cyc stays high.
  - Exactly 4 wr_ready pulses; done_beats = 4.
- wrap8 read starting at 0x18:
  - Addresses are 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14, with bte = 10.
  - cti = 111 only on 0x14.
  - 8 rd_valid pulses.
- wrap16 read at 0x3C with cmd_len = 2: cmd_len is ignored, 16 beats are issued, and the second address is 0x00.
- Linear read, cmd_len = 7, slave asserts err on beat 5:
  - cyc drops the next cycle with done = 1 and done_err = 1.
  - done_beats = 4 and 4 rd_valid pulses.
  - Same result when rty is asserted instead of err.
- Reset mid-burst:
  - wb_rst_i asserted asynchronously on beat 2 of 4; cyc and stb go to 0 in the same cycle and there is no done pulse.
  - After release, cmd_ready = 1, and a following back-to-back command is accepted and completes normally.

Source files
------------

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst initiator.
// Turns a command (we, byte address, length, burst type) plus a write-data stream
// into a classic single cycle or a registered-feedback incrementing burst
// (linear, wrap4, wrap8, wrap16). Reads come back on rd_data/rd_valid.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   cmd_*                   command handshake (valid/ready), we, adr, len, bte
//   wr_data/valid/ready     write-data stream, one word per acked write beat
//   rd_data/rd_valid        registered read data, one pulse per acked read beat
//   done/done_err           end-of-command pulse, qualified by error/retry
//   done_beats              number of acked beats of the last command
//   wb_*                    Wishbone B3 initiator signals
module wb_b3_burst_master #(
    parameter int unsigned dw = 32,
    parameter int unsigned aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [aw-1:0] cmd_adr,
    input  logic [3:0]    cmd_len,
    input  logic [1:0]    cmd_bte,
    input  logic [dw-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [dw-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic          done_err,
    output logic [4:0]    done_beats,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e        state_q, state_d;
    logic          we_q;
    logic [aw-1:0] adr_q;
    logic [4:0]    total_q;
    logic [1:0]    bte_q;
    logic [4:0]    beats_q;
    logic          err_q;
    logic [4:0]    done_beats_q;
    logic [dw-1:0] rd_data_q;
    logic          rd_valid_q;

    logic          stb;
    logic          last_beat;
    logic          ack_beat;
    logic          term_beat;
    logic [4:0]    cmd_total;
    logic [aw-1:0] adr_inc;
    logic [aw-1:0] wrap_mask;
    logic [aw-1:0] adr_next;

    // Beat total: cmd_len only matters for linear bursts.
    always_comb begin
        cmd_total = 5'd0;
        unique case (cmd_bte)
            2'b00: cmd_total = 5'({1'b0, cmd_len}) + 5'd1;
            2'b01: cmd_total = 5'd4;
            2'b10: cmd_total = 5'd8;
            2'b11: cmd_total = 5'd16;
            default: cmd_total = 5'd0;
        endcase
    end

    // Byte-address bits allowed to change on a beat; the rest hold for wraps.
    always_comb begin
        wrap_mask = '1;
        unique case (bte_q)
            2'b00: wrap_mask = '1;
            2'b01: wrap_mask = {{(aw-4){1'b0}}, 4'hc};
            2'b10: wrap_mask = {{(aw-5){1'b0}}, 5'h1c};
            2'b11: wrap_mask = {{(aw-6){1'b0}}, 6'h3c};
            default: wrap_mask = '1;
        endcase
    end

    assign adr_inc   = adr_q + aw'(4);
    assign adr_next  = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
    assign last_beat = (beats_q == total_q - 5'd1);

    // Writes stall the strobe (not the cycle) while no write word is available.
    assign stb       = (state_q == StBus) & (we_q ? wr_valid : 1'b1);
    assign term_beat = stb & (wb_err_i | wb_rty_i);
    assign ack_beat  = stb & wb_ack_i & ~wb_err_i & ~wb_rty_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        done_err  = 1'b0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        wb_sel_o  = 4'h0;
        wb_we_o   = 1'b0;
        wb_cti_o  = 3'b000;
        wb_bte_o  = 2'b00;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = StBus;
            end
            StBus: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = stb;
                wb_sel_o = 4'hf;
                wb_we_o  = we_q;
                wb_adr_o = adr_q;
                wb_dat_o = wr_data;
                wr_ready = ack_beat & we_q;
                if (total_q != 5'd1) begin
                    wb_cti_o = last_beat ? 3'b111 : 3'b010;
                    wb_bte_o = bte_q;
                end
                if (term_beat || (ack_beat && last_beat)) state_d = StDone;
            end
            StDone: begin
                done     = 1'b1;
                done_err = err_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q         <= 1'b0;
            adr_q        <= '0;
            total_q      <= 5'd0;
            bte_q        <= 2'b00;
            beats_q      <= 5'd0;
            err_q        <= 1'b0;
            done_beats_q <= 5'd0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_valid_q <= ack_beat & ~we_q;
            if (ack_beat && !we_q) rd_data_q <= wb_dat_i;
            if (state_q == StIdle && cmd_valid) begin
                we_q    <= cmd_we;
                adr_q   <= {cmd_adr[aw-1:2], 2'b00};
                total_q <= cmd_total;
                bte_q   <= cmd_bte;
                beats_q <= 5'd0;
                err_q   <= 1'b0;
            end else if (state_q == StBus) begin
                if (term_beat) begin
                    // Failing beat is not counted.
                    err_q        <= 1'b1;
                    done_beats_q <= beats_q;
                end else if (ack_beat) begin
                    beats_q <= beats_q + 5'd1;
                    adr_q   <= adr_next;
                    if (last_beat) done_beats_q <= beats_q + 5'd1;
                end
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign done_beats = done_beats_q;

endmodule

// File: tb/tb_wb_b3_burst_master.sv
module tb_wb_b3_burst_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        done_err;
    logic [4:0]  done_beats;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;

    int tests = 0;
    int fails = 0;

    wb_b3_burst_master #(.dw(32), .aw(32)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .cmd_bte    (cmd_bte),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .done_err   (done_err),
        .done_beats (done_beats),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  len;
        logic [1:0]  bte;
        int          err_beat;   // beat index answered with err/rty, -1 = none
        logic        rty;        // use rty instead of err
        logic        ack_err;    // also raise ack together with err
        int          gap;        // write beat preceded by 2 wr_valid-low cycles, -1 = none
        int          exp_beats;
        logic        exp_err;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_alast;  // address of the last strobed beat
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int idx, input int beat);
        return 32'hc0de_0000 | 32'(idx << 8) | 32'(beat);
    endfunction

    // Reference beat address: wrap bursts stay inside an aligned block of span bytes.
    function automatic logic [31:0] exp_addr(input logic [31:0] a_in, input logic [1:0] bte,
                                             input int beat);
        logic [31:0] a;
        logic [31:0] base;
        logic [31:0] span;
        a = {a_in[31:2], 2'b00};
        if (bte == 2'b00) return a + 32'(4 * beat);
        span = (bte == 2'b01) ? 32'd16 : (bte == 2'b10) ? 32'd32 : 32'd64;
        base = a - (a % span);
        return base + ((a - base + 32'(4 * beat)) % span);
    endfunction

    task automatic run_cmd(input vec_t v, input int idx);
        int          beat;
        int          gap_cnt;
        int          rdc;
        int          wrc;
        int          ntot;
        logic        fin;
        logic [31:0] last_adr;
        logic [2:0]  ecti;
        beat = 0; gap_cnt = 0; rdc = 0; wrc = 0; fin = 1'b0; last_adr = '0;
        ntot = (v.bte == 2'b00) ? int'(v.len) + 1 : (v.bte == 2'b01) ? 4 :
               (v.bte == 2'b10) ? 8 : 16;
        check($sformatf("v%0d cmd_ready_idle", idx), cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_len = v.len; cmd_bte = v.bte;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (rd_valid) begin
                check($sformatf("v%0d rd_data%0d", idx, rdc), rd_data, pat(idx, rdc));
                rdc++;
            end
            if (done) begin
                fin = 1'b1;
            end else begin
                check($sformatf("v%0d cyc", idx), wb_cyc_o, 1);
                if (v.we && beat == v.gap && gap_cnt < 2) begin
                    wr_valid = 1'b0;
                    gap_cnt++;
                end else begin
                    wr_valid = 1'b1;
                    wr_data = pat(idx, beat);
                end
                wb_dat_i = pat(idx, beat);
                #1;
                check($sformatf("v%0d stb", idx), wb_stb_o, v.we ? wr_valid : 1'b1);
                if (wb_stb_o) begin
                    ecti = (ntot == 1) ? 3'b000 : (beat == ntot - 1) ? 3'b111 : 3'b010;
                    check($sformatf("v%0d adr%0d", idx, beat), wb_adr_o,
                          exp_addr(v.adr, v.bte, beat));
                    check($sformatf("v%0d cti%0d", idx, beat), wb_cti_o, ecti);
                    check($sformatf("v%0d bte%0d", idx, beat), wb_bte_o,
                          (ntot == 1) ? 2'b00 : v.bte);
                    check($sformatf("v%0d sel", idx), wb_sel_o, 4'hf);
                    check($sformatf("v%0d we", idx), wb_we_o, v.we);
                    if (v.we) check($sformatf("v%0d dat_o", idx), wb_dat_o, wr_data);
                    last_adr = wb_adr_o;
                    if (beat == v.err_beat) begin
                        wb_err_i = ~v.rty;
                        wb_rty_i = v.rty;
                        wb_ack_i = v.ack_err;
                    end else begin
                        wb_ack_i = 1'b1;
                    end
                    #1;
                    check($sformatf("v%0d wr_ready", idx), wr_ready,
                          v.we & wb_ack_i & ~wb_err_i & ~wb_rty_i);
                    if (wr_ready) wrc++;
                    if (wb_ack_i && !wb_err_i && !wb_rty_i) beat++;
                end else begin
                    // Ack with stb low must be ignored.
                    wb_ack_i = 1'b1;
                    #1;
                    check($sformatf("v%0d wr_ready_gap", idx), wr_ready, 0);
                end
                @(posedge wb_clk_i);
                @(negedge wb_clk_i);
                wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            end
        end
        wr_valid = 1'b0;
        check($sformatf("v%0d done_seen", idx), fin, 1);
        check($sformatf("v%0d done_err", idx), done_err, v.exp_err);
        check($sformatf("v%0d done_beats", idx), done_beats, v.exp_beats);
        check($sformatf("v%0d cyc_done", idx), wb_cyc_o, 0);
        check($sformatf("v%0d stb_done", idx), wb_stb_o, 0);
        check($sformatf("v%0d cmd_ready_done", idx), cmd_ready, 0);
        check($sformatf("v%0d rd_count", idx), rdc, v.exp_rd);
        check($sformatf("v%0d wr_count", idx), wrc, v.exp_wr);
        check($sformatf("v%0d last_adr", idx), last_adr, v.exp_alast);
        @(negedge wb_clk_i);
        check($sformatf("v%0d done_pulse", idx), done, 0);
        check($sformatf("v%0d cmd_ready_after", idx), cmd_ready, 1);
        check($sformatf("v%0d done_beats_held", idx), done_beats, v.exp_beats);
    endtask

    initial begin
        //            we    adr           len   bte    errb rty  ae   gap beats err rd wr alast
        vecs[0] = '{1'b0, 32'h0000_0040, 4'd0, 2'd0, -1, 1'b0, 1'b0, -1, 1, 1'b0, 1, 0,
                    32'h0000_0040};
        vecs[1] = '{1'b1, 32'h0000_0100, 4'd3, 2'd0, -1, 1'b0, 1'b0, 2, 4, 1'b0, 0, 4,
                    32'h0000_010c};
        vecs[2] = '{1'b0, 32'h0000_0018, 4'd0, 2'd2, -1, 1'b0, 1'b0, -1, 8, 1'b0, 8, 0,
                    32'h0000_0014};
        vecs[3] = '{1'b0, 32'h0000_003c, 4'd2, 2'd3, -1, 1'b0, 1'b0, -1, 16, 1'b0, 16, 0,
                    32'h0000_0038};
        vecs[4] = '{1'b0, 32'h0000_0400, 4'd7, 2'd0, 4, 1'b0, 1'b0, -1, 4, 1'b1, 4, 0,
                    32'h0000_0410};
        vecs[5] = '{1'b0, 32'h0000_0400, 4'd7, 2'd0, 4, 1'b1, 1'b0, -1, 4, 1'b1, 4, 0,
                    32'h0000_0410};
        vecs[6] = '{1'b1, 32'h0000_0080, 4'd1, 2'd0, 0, 1'b0, 1'b1, -1, 0, 1'b1, 0, 0,
                    32'h0000_0080};
        vecs[7] = '{1'b1, 32'h0000_1008, 4'd0, 2'd1, -1, 1'b0, 1'b0, -1, 4, 1'b0, 0, 4,
                    32'h0000_1004};
        vecs[8] = '{1'b0, 32'h0000_0ff7, 4'd3, 2'd0, -1, 1'b0, 1'b0, -1, 4, 1'b0, 4, 0,
                    32'h0000_1000};

        // Reset values.
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst cyc", wb_cyc_o, 0);
        check("rst stb", wb_stb_o, 0);
        check("rst adr", wb_adr_o, 0);
        check("rst cti", wb_cti_o, 0);
        check("rst done", done, 0);
        check("rst done_err", done_err, 0);
        check("rst done_beats", done_beats, 0);
        check("rst rd_valid", rd_valid, 0);
        check("rst wr_ready", wr_ready, 0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], i);

        // Asynchronous reset during beat 2 of a 4-beat linear read.
        check("mid cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h200; cmd_len = 4'd3; cmd_bte = 2'd0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        #1;
        check("mid cyc_before", wb_cyc_o, 1);
        check("mid adr_beat2", wb_adr_o, 32'h204);
        #1 wb_rst_i = 1'b1;
        #1;
        check("mid cyc_async", wb_cyc_o, 0);
        check("mid stb_async", wb_stb_o, 0);
        check("mid rd_valid_async", rd_valid, 0);
        check("mid done_async", done, 0);
        @(posedge wb_clk_i);
        #1 check("mid done_in_reset", done, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1 check("mid done_after", done, 0);
        check("mid cmd_ready_after", cmd_ready, 1);
        check("mid done_beats_after", done_beats, 0);
        @(negedge wb_clk_i);
        run_cmd(vecs[0], 0);
        run_cmd(vecs[8], 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
